bip_control_unit: RTL and testbench



---
 rtl/bip_control_unit.sv | 206 ++++++++++++++++++++
 tb/tb_bip_control_unit.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bip_control_unit.sv
// rtl/bip_control_unit.sv - BIP accumulator processor control unit with fetch/decode pipeline
//
// Two-stage registered fetch/decode control unit for the BIP accumulator machine.
// It fetches from program memory at PC, decodes the word held in IR into datapath
// strobes, and handles PC-relative branches with a one-bubble flush, a sticky halt
// and a stall input from slow data memory.
//
// Optional feature macro: BIP_BRANCH_EN
//   defined   - opcodes 01000..01100 (BEQ/BNE/BPL/BMI/BRA) are decoded as branches
//   undefined - those opcodes are NOPs, Z/N are ignored and PC only increments
//
// Parameters:
//   PC_W        program counter width (program space 2^PC_W words)
//   OPERAND_W   operand field width (instruction is 5+OPERAND_W bits)
//
// Ports:
//   CLK          in   clock, rising edge
//   RESET_N      in   asynchronous active-low reset
//   INSTRUCTION  in   program word at address PC, opcode in the top 5 bits
//   Z, N         in   accumulator zero / negative flags
//   STALL        in   data memory not ready, freezes the unit
//   PC           out  fetch address
//   OPERAND      out  operand field of the instruction in decode
//   SEL_A        out  accumulator source: 00 RAM, 01 immediate, 10 ALU
//   SEL_B        out  ALU B source: 0 RAM, 1 immediate
//   OP           out  ALU op: 0 add, 1 subtract
//   WR_ACC       out  accumulator write enable
//   WR_RAM       out  data RAM write enable
//   RD_RAM       out  data RAM read enable
//   HALTED       out  sticky halt indicator

module bip_control_unit #(
    parameter int PC_W      = 11,
    parameter int OPERAND_W = 11
) (
    input  logic                   CLK,
    input  logic                   RESET_N,
    input  logic [4+OPERAND_W:0]   INSTRUCTION,
    input  logic                   Z,
    input  logic                   N,
    input  logic                   STALL,
    output logic [PC_W-1:0]        PC,
    output logic [OPERAND_W-1:0]   OPERAND,
    output logic [1:0]             SEL_A,
    output logic                   SEL_B,
    output logic                   OP,
    output logic                   WR_ACC,
    output logic                   WR_RAM,
    output logic                   RD_RAM,
    output logic                   HALTED
);

    localparam int IW = 5 + OPERAND_W;

    localparam logic [4:0] OPC_HLT  = 5'b00000;
    localparam logic [4:0] OPC_STO  = 5'b00001;
    localparam logic [4:0] OPC_LD   = 5'b00010;
    localparam logic [4:0] OPC_LDI  = 5'b00011;
    localparam logic [4:0] OPC_ADD  = 5'b00100;
    localparam logic [4:0] OPC_ADDI = 5'b00101;
    localparam logic [4:0] OPC_SUB  = 5'b00110;
    localparam logic [4:0] OPC_SUBI = 5'b00111;
    localparam logic [4:0] OPC_BEQ  = 5'b01000;
    localparam logic [4:0] OPC_BNE  = 5'b01001;
    localparam logic [4:0] OPC_BPL  = 5'b01010;
    localparam logic [4:0] OPC_BMI  = 5'b01011;
    localparam logic [4:0] OPC_BRA  = 5'b01100;

    logic [PC_W-1:0] pc_q, pc_d;
    logic [IW-1:0]   ir_q, ir_d;
    logic [PC_W-1:0] ir_pc_q, ir_pc_d;
    logic            ir_valid_q, ir_valid_d;
    logic            halted_q, halted_d;

    logic [4:0]      opcode;
    logic            active;
    logic            halt_req;
    logic            taken;
    logic [PC_W-1:0] offset;
    logic [PC_W-1:0] target;

    assign opcode = ir_q[IW-1 -: 5];
    assign active = ir_valid_q && !halted_q;

    // Branch offset: sign-extend a narrow operand, truncate a wide one.
    generate
        if (OPERAND_W >= PC_W) begin : g_off_trunc
            assign offset = ir_q[PC_W-1:0];
        end else begin : g_off_sext
            assign offset = {{(PC_W-OPERAND_W){ir_q[OPERAND_W-1]}}, ir_q[OPERAND_W-1:0]};
        end
    endgenerate

    assign target   = ir_pc_q + offset;
    assign halt_req = active && (opcode == OPC_HLT);

`ifdef BIP_BRANCH_EN
    always_comb begin
        taken = 1'b0;
        if (active) begin
            case (opcode)
                OPC_BEQ: taken = Z;
                OPC_BNE: taken = !Z;
                OPC_BPL: taken = !N;
                OPC_BMI: taken = N;
                OPC_BRA: taken = 1'b1;
                default: taken = 1'b0;
            endcase
        end
    end
`else
    assign taken = 1'b0;
    logic unused_flags;
    assign unused_flags = Z ^ N;
`endif

    // Next state: everything holds while stalled or halted. A halt edge does not
    // fetch, so PC stays at the address after the HLT. A taken branch still loads
    // IR but marks it invalid, which turns the wrong-path word into a bubble.
    always_comb begin
        pc_d       = pc_q;
        ir_d       = ir_q;
        ir_pc_d    = ir_pc_q;
        ir_valid_d = ir_valid_q;
        halted_d   = halted_q;
        if (!STALL && !halted_q) begin
            if (halt_req) begin
                halted_d = 1'b1;
            end else begin
                pc_d       = taken ? target : (pc_q + PC_W'(1));
                ir_d       = INSTRUCTION;
                ir_pc_d    = pc_q;
                ir_valid_d = !taken;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            pc_q       <= '0;
            ir_q       <= '0;
            ir_pc_q    <= '0;
            ir_valid_q <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            ir_pc_q    <= ir_pc_d;
            ir_valid_q <= ir_valid_d;
            halted_q   <= halted_d;
        end
    end

    logic [1:0] sel_a_dec;
    logic       sel_b_dec, op_dec, wr_acc_dec, wr_ram_dec, rd_ram_dec;

    always_comb begin
        sel_a_dec  = 2'b00;
        sel_b_dec  = 1'b0;
        op_dec     = 1'b0;
        wr_acc_dec = 1'b0;
        wr_ram_dec = 1'b0;
        rd_ram_dec = 1'b0;
        if (active) begin
            case (opcode)
                OPC_STO: wr_ram_dec = 1'b1;
                OPC_LD: begin
                    sel_a_dec  = 2'b00;
                    rd_ram_dec = 1'b1;
                    wr_acc_dec = 1'b1;
                end
                OPC_LDI: begin
                    sel_a_dec  = 2'b01;
                    wr_acc_dec = 1'b1;
                end
                OPC_ADD, OPC_SUB: begin
                    sel_a_dec  = 2'b10;
                    op_dec     = opcode[1];
                    rd_ram_dec = 1'b1;
                    wr_acc_dec = 1'b1;
                end
                OPC_ADDI, OPC_SUBI: begin
                    sel_a_dec  = 2'b10;
                    sel_b_dec  = 1'b1;
                    op_dec     = opcode[1];
                    wr_acc_dec = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Writes are held off while stalled so the instruction commits exactly once,
    // on the first cycle STALL is low; reads and selects stay up so data memory
    // keeps seeing the request.
    assign PC      = pc_q;
    assign OPERAND = ir_q[OPERAND_W-1:0];
    assign SEL_A   = sel_a_dec;
    assign SEL_B   = sel_b_dec;
    assign OP      = op_dec;
    assign WR_ACC  = wr_acc_dec && !STALL;
    assign WR_RAM  = wr_ram_dec && !STALL;
    assign RD_RAM  = rd_ram_dec;
    assign HALTED  = halted_q;

endmodule

// File: tb/tb_bip_control_unit.sv
// tb/tb_bip_control_unit.sv - directed self-checking bench for bip_control_unit

module tb_bip_control_unit;

`ifdef BIP_BRANCH_EN
    localparam bit BR_EN = 1'b1;
`else
    localparam bit BR_EN = 1'b0;
`endif

    localparam logic [4:0] HLT  = 5'b00000;
    localparam logic [4:0] STO  = 5'b00001;
    localparam logic [4:0] LD   = 5'b00010;
    localparam logic [4:0] LDI  = 5'b00011;
    localparam logic [4:0] ADDI = 5'b00101;
    localparam logic [4:0] BEQ  = 5'b01000;
    localparam logic [4:0] BNE  = 5'b01001;
    localparam logic [4:0] BPL  = 5'b01010;
    localparam logic [4:0] BMI  = 5'b01011;
    localparam logic [4:0] BRA  = 5'b01100;
    localparam logic [4:0] NOP  = 5'b01111;

    // {SEL_A, SEL_B, OP, WR_ACC, WR_RAM, RD_RAM}
    localparam logic [6:0] S_NONE     = 7'b00_0_0_0_0_0;
    localparam logic [6:0] S_LDI      = 7'b01_0_0_1_0_0;
    localparam logic [6:0] S_ADDI     = 7'b10_1_0_1_0_0;
    localparam logic [6:0] S_STO      = 7'b00_0_0_0_1_0;
    localparam logic [6:0] S_LD       = 7'b00_0_0_1_0_1;
    localparam logic [6:0] S_LD_STALL = 7'b00_0_0_0_0_1;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic RESET_N = 1'b1;
    logic rst2_n  = 1'b0;
    logic Z = 1'b0, N = 1'b0, STALL = 1'b0;

    logic [15:0] mem [0:2047];
    logic [15:0] instr;
    logic [10:0] pc, operand;
    logic [1:0]  sel_a;
    logic        sel_b, op, wr_acc, wr_ram, rd_ram, halted;
    logic [6:0]  strb;

    assign instr = mem[pc];
    assign strb  = {sel_a, sel_b, op, wr_acc, wr_ram, rd_ram};

    bip_control_unit #(.PC_W(11), .OPERAND_W(11)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .INSTRUCTION(instr), .Z(Z), .N(N), .STALL(STALL),
        .PC(pc), .OPERAND(operand), .SEL_A(sel_a), .SEL_B(sel_b), .OP(op),
        .WR_ACC(wr_acc), .WR_RAM(wr_ram), .RD_RAM(rd_ram), .HALTED(halted)
    );

    logic [8:0] mem2 [0:15];
    logic [8:0] instr2;
    logic [3:0] pc2, operand2;
    logic [1:0] sel_a2;
    logic       sel_b2, op2, wr_acc2, wr_ram2, rd_ram2, halted2;
    logic [6:0] strb2;

    assign instr2 = mem2[pc2];
    assign strb2  = {sel_a2, sel_b2, op2, wr_acc2, wr_ram2, rd_ram2};

    bip_control_unit #(.PC_W(4), .OPERAND_W(4)) dut2 (
        .CLK(CLK), .RESET_N(rst2_n), .INSTRUCTION(instr2), .Z(Z), .N(N), .STALL(STALL),
        .PC(pc2), .OPERAND(operand2), .SEL_A(sel_a2), .SEL_B(sel_b2), .OP(op2),
        .WR_ACC(wr_acc2), .WR_RAM(wr_ram2), .RD_RAM(rd_ram2), .HALTED(halted2)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] enc(input logic [4:0] opc, input logic [10:0] arg);
        return {opc, arg};
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < 2048; i++) mem[i] = enc(NOP, 11'd0);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic do_reset(input string tag);
        @(negedge CLK);
        RESET_N = 1'b0;
        #1;
        check_eq({tag, "_rst_pc"}, pc, 0);
        check_eq({tag, "_rst_operand"}, operand, 0);
        check_eq({tag, "_rst_strobes"}, strb, S_NONE);
        check_eq({tag, "_rst_halted"}, halted, 0);
        @(negedge CLK);
        RESET_N = 1'b1;
    endtask

    // Conditional branch table: BEQ +3 at address 6 under various flags.
    logic [4:0] t_op [0:8] = '{BEQ, BEQ, BNE, BNE, BPL, BPL, BMI, BMI, BRA};
    logic       t_z  [0:8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic       t_n  [0:8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic       t_tk [0:8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    initial begin
        // Straight-line LDI 5; ADDI 3; STO 7
        clear_mem();
        mem[0] = enc(LDI, 11'd5);
        mem[1] = enc(ADDI, 11'd3);
        mem[2] = enc(STO, 11'd7);
        do_reset("line");
        step(1);
        check_eq("c1_pc", pc, 1);
        check_eq("c1_operand", operand, 5);
        check_eq("c1_strobes", strb, S_LDI);
        step(1);
        check_eq("c2_pc", pc, 2);
        check_eq("c2_operand", operand, 3);
        check_eq("c2_strobes", strb, S_ADDI);
        step(1);
        check_eq("c3_pc", pc, 3);
        check_eq("c3_operand", operand, 7);
        check_eq("c3_strobes", strb, S_STO);

        // BRA -2 at address 4
        clear_mem();
        mem[2] = enc(LDI, 11'd9);
        mem[4] = enc(BRA, 11'h7FE);
        mem[5] = enc(LDI, 11'd1);
        do_reset("bra");
        step(5);
        check_eq("bra_dec_pc", pc, 5);
        check_eq("bra_dec_strobes", strb, S_NONE);
        step(1);
        check_eq("bra_next_pc", pc, BR_EN ? 2 : 6);
        check_eq("bra_bubble_strobes", strb, BR_EN ? S_NONE : S_LDI);
        step(1);
        check_eq("bra_after_pc", pc, BR_EN ? 3 : 7);
        check_eq("bra_after_operand", operand, BR_EN ? 9 : 0);
        check_eq("bra_after_strobes", strb, BR_EN ? S_LDI : S_NONE);

        // Conditional branches +3 at address 6
        for (int t = 0; t < 9; t++) begin
            logic tk;
            clear_mem();
            mem[6] = enc(t_op[t], 11'd3);
            mem[7] = enc(LDI, 11'd2);
            mem[8] = enc(LDI, 11'd4);
            mem[9] = enc(LDI, 11'd6);
            Z = t_z[t];
            N = t_n[t];
            tk = BR_EN && t_tk[t];
            do_reset($sformatf("br%0d", t));
            step(7);
            check_eq($sformatf("br%0d_dec_pc", t), pc, 7);
            step(1);
            check_eq($sformatf("br%0d_next_pc", t), pc, tk ? 9 : 8);
            check_eq($sformatf("br%0d_next_strobes", t), strb, tk ? S_NONE : S_LDI);
            step(1);
            check_eq($sformatf("br%0d_after_pc", t), pc, tk ? 10 : 9);
            check_eq($sformatf("br%0d_after_operand", t), operand, tk ? 6 : 4);
        end
        Z = 1'b0;
        N = 1'b0;

        // LD held by STALL
        clear_mem();
        mem[0] = enc(LD, 11'd12);
        do_reset("stall");
        step(1);
        check_eq("ld_strobes", strb, S_LD);
        STALL = 1'b1;
        #1;
        check_eq("stall0_strobes", strb, S_LD_STALL);
        for (int s = 1; s <= 2; s++) begin
            step(1);
            check_eq($sformatf("stall%0d_pc", s), pc, 1);
            check_eq($sformatf("stall%0d_operand", s), operand, 12);
            check_eq($sformatf("stall%0d_strobes", s), strb, S_LD_STALL);
        end
        STALL = 1'b0;
        #1;
        check_eq("unstall_strobes", strb, S_LD);
        check_eq("unstall_pc", pc, 1);
        step(1);
        check_eq("post_stall_pc", pc, 2);
        check_eq("post_stall_strobes", strb, S_NONE);

        // HLT at address 3, first stalled, then reset pulse while halted
        clear_mem();
        mem[3] = enc(HLT, 11'd0);
        mem[4] = enc(LDI, 11'd1);
        do_reset("hlt");
        step(4);
        check_eq("hlt_dec_pc", pc, 4);
        check_eq("hlt_dec_halted", halted, 0);
        STALL = 1'b1;
        step(1);
        check_eq("hlt_stall_halted", halted, 0);
        check_eq("hlt_stall_pc", pc, 4);
        STALL = 1'b0;
        step(1);
        check_eq("halted_flag", halted, 1);
        check_eq("halted_pc", pc, 4);
        check_eq("halted_strobes", strb, S_NONE);
        step(2);
        check_eq("halted_hold_pc", pc, 4);
        check_eq("halted_hold_flag", halted, 1);
        check_eq("halted_hold_strobes", strb, S_NONE);
        #2;
        RESET_N = 1'b0;
        #1;
        check_eq("midrst_pc", pc, 0);
        check_eq("midrst_halted", halted, 0);
        #1;
        RESET_N = 1'b1;
        step(1);
        check_eq("after_midrst_pc", pc, 1);

        // PC_W=4: wrap and BRA +1 at address 15 to target 0
        for (int i = 0; i < 16; i++) mem2[i] = {NOP, 4'd0};
        mem2[14] = {LDI, 4'd3};
        mem2[15] = {BRA, 4'd1};
        mem2[0]  = {LDI, 4'd5};
        @(negedge CLK);
        rst2_n = 1'b1;
        #1;
        rst2_n = 1'b0;
        #1;
        check_eq("w_rst_pc", pc2, 0);
        @(negedge CLK);
        rst2_n = 1'b1;
        step(15);
        check_eq("w_pc15", pc2, 15);
        check_eq("w_operand14", operand2, 3);
        check_eq("w_strobes14", strb2, S_LDI);
        step(1);
        check_eq("w_pc_wrap", pc2, 0);
        check_eq("w_operand15", operand2, 1);
        step(1);
        check_eq("w_bra_pc", pc2, BR_EN ? 0 : 1);
        check_eq("w_bra_strobes", strb2, BR_EN ? S_NONE : S_LDI);
        step(1);
        check_eq("w_after_pc", pc2, BR_EN ? 1 : 2);
        check_eq("w_after_operand", operand2, BR_EN ? 5 : 0);
        check_eq("w_halted", halted2, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
